mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that consumes the processor's data-side store/load traffic, directly downstream of the MIPS core's ALU address and register-file store-data path. Stores to its data register enqueue bytes in a small FIFO. An 8N1 serializer drains the FIFO onto a single `tx` line at a parameterized bit rate. A status register is readable through the same address decode, so software can poll before writing.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/mmio_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared state encoding, register offsets and status bit indices
//            for the memory-mapped UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_t;

    localparam logic [31:0] UART_DATA_OFS = 32'd0;
    localparam logic [31:0] UART_STAT_OFS = 32'd4;

    localparam int UART_STAT_BUSY      = 0;
    localparam int UART_STAT_EMPTY     = 1;
    localparam int UART_STAT_FULL      = 2;
    localparam int UART_STAT_OVF       = 3;
    localparam int UART_STAT_COUNT_LSB = 4;
    localparam int UART_STAT_PARITY    = 8;

    // The status count field is 4 bits wide; deeper FIFOs report 15.
    function automatic logic [3:0] sat_count4(input logic [31:0] n);
        return (n > 32'd15) ? 4'hF : n[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, power-of-two depth, occupancy-count based
//            full/empty flags. A push into a full FIFO is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped UART transmitter: stores to the data register feed
//            a FIFO drained by an 8N1 serializer; status is load-readable.
//            Define UART_TX_PARITY_EN to insert an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);
    localparam int                BAUD_W      = $clog2(CLK_DIV);
    localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0]       c_data_addr = BASE_ADDR + UART_DATA_OFS;
    localparam logic [31:0]       c_stat_addr = BASE_ADDR + UART_STAT_OFS;
    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLK_DIV - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic              c_parity_en = 1'b1;
`else
    localparam logic              c_parity_en = 1'b0;
`endif

    uart_state_t       r_state, w_state_nxt;
    logic [BAUD_W-1:0] r_baud, w_baud_nxt;
    logic [2:0]        r_bit, w_bit_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              r_parity, w_parity_nxt;
    logic              r_tx, w_tx_nxt;
    logic              r_overflow;

    logic              w_tick;
    logic              w_load;
    logic              w_pop;
    logic              w_data_wr;
    logic              w_stat_wr;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_fifo_data;
    logic [CNT_W-1:0]  w_count;
    logic [31:0]       w_status;
    logic              w_unused_wdata;

    assign w_data_wr      = MemWrite && (Address == c_data_addr);
    assign w_stat_wr      = MemWrite && (Address == c_stat_addr);
    assign w_tick         = (r_baud == c_baud_last);
    assign w_unused_wdata = ^WriteData[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_data_wr),
        .i_data  (WriteData[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = w_tick ? '0 : r_baud + BAUD_W'(1);
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_load       = 1'b0;
        case (r_state)
            UART_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = UART_START;
                    w_load      = 1'b1;
                end
            end
            UART_START: begin
                if (w_tick) begin
                    w_state_nxt = UART_DATA;
                end
            end
            UART_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_parity_en ? UART_PARITY : UART_STOP;
                    end
                end
            end
            UART_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = UART_STOP;
                end
            end
            UART_STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (w_tick) begin
                    if (!w_empty) begin
                        w_state_nxt = UART_START;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = UART_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = UART_IDLE;
            end
        endcase

        if (w_load) begin
            w_shift_nxt  = w_fifo_data;
            w_parity_nxt = ^w_fifo_data;
            w_bit_nxt    = 3'd0;
        end
        if ((w_state_nxt != r_state) || (r_state == UART_IDLE)) begin
            w_baud_nxt = '0;
        end

        // tx is registered from the next-state view so it toggles on the
        // same edge as the state change.
        case (w_state_nxt)
            UART_START:  w_tx_nxt = 1'b0;
            UART_DATA:   w_tx_nxt = w_shift_nxt[0];
            UART_PARITY: w_tx_nxt = w_parity_nxt;
            default:     w_tx_nxt = 1'b1;
        endcase
    end

    assign w_pop = w_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= UART_IDLE;
            r_baud   <= '0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_tx     <= w_tx_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_data_wr && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (w_stat_wr && WriteData[UART_STAT_OVF]) begin
            r_overflow <= 1'b0;
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != UART_IDLE) || !w_empty;

    always_comb begin
        w_status                                   = '0;
        w_status[UART_STAT_BUSY]                   = busy;
        w_status[UART_STAT_EMPTY]                  = w_empty;
        w_status[UART_STAT_FULL]                   = w_full;
        w_status[UART_STAT_OVF]                    = r_overflow;
        w_status[UART_STAT_COUNT_LSB +: 4]         = sat_count4(32'(w_count));
        w_status[UART_STAT_PARITY]                 = c_parity_en;
        ReadData = (MemRead && (Address == c_stat_addr)) ? w_status : 32'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Brief    : Self-checking bench for mmio_uart_tx with a serial receiver
//            model and randomized byte traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;
    localparam int          CLK_DIV    = 4;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] BASE       = 32'h1001_0000;
    localparam logic [31:0] STAT       = BASE + 32'd4;
`ifdef UART_TX_PARITY_EN
    localparam int          PAR_EN     = 1;
`else
    localparam int          PAR_EN     = 0;
`endif
    localparam int          SLOTS      = 10 + PAR_EN;
    localparam int          FRAME      = SLOTS * CLK_DIV;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_status(input int count, input int ovf,
                                               input int full, input int empty,
                                               input int bsy);
        int c;
        c = (count > 15) ? 15 : count;
        return 32'(PAR_EN * 256 + c * 16 + ovf * 8 + full * 4 + empty * 2 + bsy);
    endfunction

    function automatic logic model_tx(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (PAR_EN != 0 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic p;
        p = (PAR_EN != 0) ? ^b : 1'b0;
        return {1'b0, b, p, 1'b1};
    endfunction

    // ---------------- serial receiver (samples mid-slot) ----------------
    typedef struct {
        logic [7:0] data;
        logic       start_bit;
        logic       par_bit;
        logic       stop_bit;
        int         start_cyc;
    } rx_frame_t;

    rx_frame_t  rx_q[$];
    logic       rx_active = 1'b0;
    int         rx_cnt    = 0;
    int         rx_start  = 0;
    logic [7:0] rx_data   = 8'd0;
    logic       rx_sbit   = 1'b0;
    logic       rx_par    = 1'b0;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            rx_active <= 1'b0;
            rx_cnt    <= 0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active <= 1'b1;
                rx_cnt    <= 1;
                rx_start  <= cyc;
                rx_par    <= 1'b0;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % CLK_DIV == 1) begin
                if (rx_cnt / CLK_DIV == 0) begin
                    rx_sbit <= tx;
                end else if (rx_cnt / CLK_DIV <= 8) begin
                    rx_data[rx_cnt / CLK_DIV - 1] <= tx;
                end else if (rx_cnt / CLK_DIV == SLOTS - 1) begin
                    rx_q.push_back('{data: rx_data, start_bit: rx_sbit, par_bit: rx_par,
                                     stop_bit: tx, start_cyc: rx_start});
                    rx_active <= 1'b0;
                end else begin
                    rx_par <= tx;
                end
            end
        end
    end

    // ---------------- bus helpers (no checking) ----------------
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        Address = addr;
        MemRead = 1'b1;
        #1;
        data    = ReadData;
        MemRead = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && !rx_active) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] st;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got tx=%b busy=%b expected tx=1 busy=0", c, tx, busy);
            end
        end
        @(posedge clk);
        #1;
        bus_read(STAT, st);
        n_checks++;
        if (st !== exp_status(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected %h", st, exp_status(0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_single_frame(input logic [7:0] b);
        logic [31:0] wd;
        logic [31:0] st;
        logic        exp_tx;
        logic        exp_busy;
        bit          ok;
        rx_q.delete();
        wd      = $urandom();
        wd[7:0] = b;
        bus_write(BASE, wd);
        for (int c = 0; c <= FRAME + 1; c++) begin
            @(negedge clk);
            exp_tx   = (c >= 1 && c <= FRAME) ? model_tx(b, (c - 1) / CLK_DIV) : 1'b1;
            exp_busy = (c <= FRAME);
            n_checks++;
            if (tx !== exp_tx || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL frame_%h c%0d: got tx=%b busy=%b expected tx=%b busy=%b",
                         b, c, tx, busy, exp_tx, exp_busy);
            end
        end
        wait_idle(10, ok);
        n_checks++;
        if (rx_q.size() != 1) begin
            n_fail++;
            $display("FAIL frame_%h_rxcount: got %0d expected 1", b, rx_q.size());
        end else if ({rx_q[0].start_bit, rx_q[0].data, rx_q[0].par_bit, rx_q[0].stop_bit} !== exp_frame(b)) begin
            n_fail++;
            $display("FAIL frame_%h_rx: got %h expected %h", b,
                     {rx_q[0].start_bit, rx_q[0].data, rx_q[0].par_bit, rx_q[0].stop_bit}, exp_frame(b));
        end
        bus_read(STAT, st);
        n_checks++;
        if (st !== exp_status(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL frame_%h_status: got %h expected %h", b, st, exp_status(0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  q_exp[$];
        logic [7:0]  b;
        logic [31:0] wd;
        logic [31:0] st;
        bit          ok;
        rx_q.delete();
        for (int i = 0; i < 5; i++) begin
            b       = 8'($urandom());
            q_exp.push_back(b);
            wd      = $urandom();
            wd[7:0] = b;
            bus_write(BASE, wd);
        end
        bus_read(STAT, st);
        n_checks++;
        if (st !== exp_status(4, 0, 1, 0, 1)) begin
            n_fail++;
            $display("FAIL ovf_five_fit: got %h expected %h", st, exp_status(4, 0, 1, 0, 1));
        end
        bus_write(BASE, $urandom());
        bus_read(STAT, st);
        n_checks++;
        if (st !== exp_status(4, 1, 1, 0, 1)) begin
            n_fail++;
            $display("FAIL ovf_sixth: got %h expected %h", st, exp_status(4, 1, 1, 0, 1));
        end
        wd    = $urandom();
        wd[3] = 1'b1;
        bus_write(STAT, wd);
        bus_read(STAT, st);
        n_checks++;
        if (st !== exp_status(4, 0, 1, 0, 1)) begin
            n_fail++;
            $display("FAIL ovf_clear: got %h expected %h", st, exp_status(4, 0, 1, 0, 1));
        end
        wait_idle(6 * FRAME + 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ovf_drain_timeout: got busy=%b expected 0", busy);
        end
        n_checks++;
        if (rx_q.size() != q_exp.size()) begin
            n_fail++;
            $display("FAIL ovf_rxcount: got %0d expected %0d", rx_q.size(), q_exp.size());
        end else begin
            for (int i = 0; i < q_exp.size(); i++) begin
                n_checks++;
                if ({rx_q[i].start_bit, rx_q[i].data, rx_q[i].par_bit, rx_q[i].stop_bit} !== exp_frame(q_exp[i])) begin
                    n_fail++;
                    $display("FAIL ovf_rx%0d: got %h expected %h", i,
                             {rx_q[i].start_bit, rx_q[i].data, rx_q[i].par_bit, rx_q[i].stop_bit},
                             exp_frame(q_exp[i]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q_exp[$];
        logic [7:0] b;
        int         k0;
        int         t_fall;
        rx_q.delete();
        t_fall = -1;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom());
            q_exp.push_back(b);
            bus_write(BASE, {24'($urandom()), b});
            if (i == 0) k0 = cyc;
        end
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                t_fall = cyc;
                break;
            end
        end
        n_checks++;
        if (t_fall - (k0 + 1) != 3 * FRAME) begin
            n_fail++;
            $display("FAIL b2b_busy_len: got %0d expected %0d", t_fall - (k0 + 1), 3 * FRAME);
        end
        n_checks++;
        if (rx_q.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_rxcount: got %0d expected 3", rx_q.size());
        end else begin
            n_checks++;
            if (rx_q[0].start_cyc != k0 + 1) begin
                n_fail++;
                $display("FAIL b2b_latency: got %0d expected %0d", rx_q[0].start_cyc, k0 + 1);
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({rx_q[i].start_bit, rx_q[i].data, rx_q[i].par_bit, rx_q[i].stop_bit} !== exp_frame(q_exp[i])) begin
                    n_fail++;
                    $display("FAIL b2b_rx%0d: got %h expected %h", i,
                             {rx_q[i].start_bit, rx_q[i].data, rx_q[i].par_bit, rx_q[i].stop_bit},
                             exp_frame(q_exp[i]));
                end
                if (i > 0) begin
                    n_checks++;
                    if (rx_q[i].start_cyc - rx_q[i-1].start_cyc != FRAME) begin
                        n_fail++;
                        $display("FAIL b2b_gap%0d: got %0d expected %0d", i,
                                 rx_q[i].start_cyc - rx_q[i-1].start_cyc, FRAME);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_traffic();
        logic [7:0]  q_exp[$];
        logic [7:0]  b;
        logic [31:0] rd;
        int          nb;
        bit          ok;
        for (int burst = 0; burst < 4; burst++) begin
            rx_q.delete();
            q_exp.delete();
            nb = $urandom_range(4, 1);
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom());
                q_exp.push_back(b);
                bus_write(BASE, {24'($urandom()), b});
                bus_write(BASE + 32'd8 + 32'($urandom_range(15, 0)) * 32'd4, $urandom());
                bus_read(BASE, rd);
                n_checks++;
                if (rd !== 32'd0) begin
                    n_fail++;
                    $display("FAIL rnd_data_read: got %h expected 00000000", rd);
                end
                bus_read(BASE - 32'd4, rd);
                n_checks++;
                if (rd !== 32'd0) begin
                    n_fail++;
                    $display("FAIL rnd_other_read: got %h expected 00000000", rd);
                end
                repeat ($urandom_range(3, 0)) begin
                    @(posedge clk);
                    #1;
                end
            end
            wait_idle(6 * FRAME, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rnd_timeout burst%0d: got busy=%b expected 0", burst, busy);
            end
            n_checks++;
            if (rx_q.size() != q_exp.size()) begin
                n_fail++;
                $display("FAIL rnd_rxcount burst%0d: got %0d expected %0d", burst, rx_q.size(), q_exp.size());
            end else begin
                for (int i = 0; i < q_exp.size(); i++) begin
                    n_checks++;
                    if ({rx_q[i].start_bit, rx_q[i].data, rx_q[i].par_bit, rx_q[i].stop_bit} !== exp_frame(q_exp[i])) begin
                        n_fail++;
                        $display("FAIL rnd_rx burst%0d byte%0d: got %h expected %h", burst, i,
                                 {rx_q[i].start_bit, rx_q[i].data, rx_q[i].par_bit, rx_q[i].stop_bit},
                                 exp_frame(q_exp[i]));
                    end
                end
            end
            bus_read(STAT, rd);
            n_checks++;
            if (rd !== exp_status(0, 0, 0, 1, 0)) begin
                n_fail++;
                $display("FAIL rnd_status burst%0d: got %h expected %h", burst, rd, exp_status(0, 0, 0, 1, 0));
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] st;
        rx_q.delete();
        bus_write(BASE, 32'h0000_0000);
        bus_write(BASE, $urandom());
        bus_write(BASE, $urandom());
        repeat (12) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_data_low: got tx=%b expected 0", tx);
        end
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
        end
        bus_read(STAT, st);
        n_checks++;
        if (st !== exp_status(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL rstmid_status_in_reset: got %h expected %h", st, exp_status(0, 0, 0, 1, 0));
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_after c%0d: got tx=%b busy=%b expected tx=1 busy=0", c, tx, busy);
            end
        end
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_residual: got %0d frames expected 0", rx_q.size());
        end
        @(posedge clk);
        #1;
        bus_read(STAT, st);
        n_checks++;
        if (st !== exp_status(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL rstmid_status: got %h expected %h", st, exp_status(0, 0, 0, 1, 0));
        end
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Address   = 32'd0;
        WriteData = 32'd0;
        test_reset();
        test_single_frame(8'h55);
        test_single_frame(8'h07);
        test_overflow();
        test_back_to_back();
        test_random_traffic();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
